alu_result_serializer: RTL and testbench

- Downstream stage of the ALU arithmetic unit: captures each valid arithmetic result (2*WIDTH-bit value plus carry) and buffers it in a small FIFO.
- Emits each buffered result as a byte-wide framed stream under a valid/ready handshake, for a UART/SPI transmitter or debug capture port.
- Absorbs bursts where the arithmetic unit flags a result every cycle, and reports results dropped due to overflow.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_res_fifo.sv | 51 +++++
 rtl/alu_result_serializer.sv | 127 ++++++++++++
 tb/tb_alu_result_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result serializer.
// Holds serializer states, the frame header nibble and byte-count helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } ser_state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  function automatic int bytes_per_result(input int width);
    return (2 * width) / 8;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic carry);
    return {HDR_NIBBLE, 3'b000, carry};
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO for captured results; head is readable combinationally.
// Latency 1 cycle push-to-visible; push while full is accepted only with a same-cycle pop.
// Backpressure: caller must gate push on full (or pop); pops on empty are ignored.
module alu_res_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  output logic [DW-1:0]            pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (!wr_en && rd_en) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and emits each as a framed byte stream: header {A,000,carry} then data MSB first.
// Latency: result sampled at edge k shows its header after edge k+2; back-to-back frames have no gap.
// Backpressure: tx_valid/tx_ready stalls hold the byte; a full FIFO with no pop drops and sets overflow.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*WIDTH-1:0]       res_data,
  input  logic                     res_carry,
  input  logic                     res_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     busy
);

  localparam int RW = 2 * WIDTH;
  localparam int NB = bytes_per_result(WIDTH);
  localparam int IW = $clog2(NB) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  ser_state_t    state;
  logic [RW-1:0] sh_dat;
  logic          sh_carry;
  logic [IW-1:0] idx;
  logic [RW:0]   head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_vld;
  logic          push_vld;
  logic          tx_fire;
  logic          ovf_set;

  assign tx_fire  = tx_valid && tx_ready;
  assign pop_vld  = !fifo_empty && ((state == IDLE) || (state == DATA && tx_fire && tx_last));
  assign push_vld = res_valid && (!fifo_full || pop_vld);
  assign ovf_set  = res_valid && fifo_full && !pop_vld;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  alu_res_fifo #(
    .DW    (RW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_vld),
    .push_dat ({res_carry, res_data}),
    .pop      (pop_vld),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sh_dat   <= '0;
      sh_carry <= 1'b0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sh_dat   <= head_dat[RW-1:0];
            sh_carry <= head_dat[RW];
            state    <= HDR;
          end
        end
        HDR: begin
          // First HDR cycle after IDLE presents the header from the freshly loaded shift register.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= hdr_byte(sh_carry);
          end else if (tx_ready) begin
            state   <= DATA;
            idx     <= '0;
            tx_data <= sh_dat[RW-1 -: 8];
            sh_dat  <= sh_dat << 8;
            tx_last <= (LAST_IDX == '0);
          end
        end
        DATA: begin
          if (tx_fire) begin
            if (tx_last) begin
              tx_last <= 1'b0;
              if (!fifo_empty) begin
                sh_dat   <= head_dat[RW-1:0];
                sh_carry <= head_dat[RW];
                tx_data  <= hdr_byte(head_dat[RW]);
                state    <= HDR;
              end else begin
                tx_valid <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              idx     <= idx + 1'b1;
              tx_data <= sh_dat[RW-1 -: 8];
              sh_dat  <= sh_dat << 8;
              tx_last <= ((idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed and randomized bench for alu_result_serializer against a byte-queue frame model.
module tb_alu_result_serializer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int NB    = (2 * WIDTH) / 8;

  logic                   clk;
  logic                   reset_n;
  logic [2*WIDTH-1:0]     res_data;
  logic                   res_carry;
  logic                   res_valid;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx_last;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   ovf_clr;
  logic                   busy;

  alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_valid  (res_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   first_xfer = -1;
  int   last_xfer = -1;
  int   inflight = 0;
  bit [7:0] exp_dat_q[$];
  bit       exp_last_q[$];
  bit       prev_stall = 0;
  logic [7:0] prev_dat;
  logic       prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected frame: header, then NB data bytes MSB first, last flag on the final byte.
  task automatic add_frame(input logic [2*WIDTH-1:0] d, input logic c);
    exp_dat_q.push_back({4'hA, 3'b000, c});
    exp_last_q.push_back(1'b0);
    for (int i = NB - 1; i >= 0; i--) begin
      exp_dat_q.push_back(d[i*8 +: 8]);
      exp_last_q.push_back(i == 0);
    end
  endtask

  task automatic push_res(input logic [2*WIDTH-1:0] d, input logic c, input bit kept);
    res_data  = d;
    res_carry = c;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    if (kept) add_frame(d, c);
  endtask

  // One clock: choose tx_ready, check any transfer and stall stability, then advance.
  task automatic cycle(input int mode);
    case (mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    if (prev_stall) begin
      check("stall_vld", tx_valid, 1);
      check("stall_dat", tx_data, prev_dat);
      check("stall_last", tx_last, prev_last);
    end
    if (tx_valid && tx_ready) begin
      check("byte_expected", exp_dat_q.size() != 0, 1);
      if (exp_dat_q.size() != 0) begin
        bit [7:0] ed;
        bit       el;
        ed = exp_dat_q.pop_front();
        el = exp_last_q.pop_front();
        check("tx_data", tx_data, ed);
        check("tx_last", tx_last, el);
        if (el) inflight--;
      end
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_dat   = tx_data;
    prev_last  = tx_last;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    prev_stall = 0;
    while (exp_dat_q.size() != 0 && n < budget) begin
      cycle(mode);
      n++;
    end
    check("drain_done", exp_dat_q.size(), 0);
  endtask

  initial begin
    int nvalid;
    int sent;
    int n;
    reset_n   = 1'b0;
    res_data  = '0;
    res_carry = 1'b0;
    res_valid = 1'b0;
    tx_ready  = 1'b0;
    ovf_clr   = 1'b0;
    #12;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single result with latency checks.
    tx_ready = 1'b1;
    push_res(32'h0001_2345, 1'b1, 1);
    check("lat_k_cnt", fifo_count, 1);
    check("lat_k_vld", tx_valid, 0);
    check("lat_k_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_k1_vld", tx_valid, 0);
    check("lat_k1_cnt", fifo_count, 0);
    @(posedge clk); #1;
    check("lat_k2_vld", tx_valid, 1);
    check("lat_k2_hdr", tx_data, 8'hA1);
    drain(0, 50);
    check("single_end_vld", tx_valid, 0);
    check("single_end_busy", busy, 0);

    // Toggling backpressure.
    tx_ready = 1'b0;
    push_res(32'h0001_2345, 1'b1, 1);
    drain(1, 100);
    check("bp_end_vld", tx_valid, 0);

    // Overflow: capacity is DEPTH in the FIFO plus one in the shift register.
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_res(32'(i), 1'b0, i <= DEPTH + 1);
    check("ovf_cnt", fifo_count, DEPTH);
    check("ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    push_res(32'd7, 1'b0, 0);
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_cnt_kept", fifo_count, DEPTH);
    drain(0, 200);
    check("ovf_end_busy", busy, 0);

    // Back-to-back frames with no gap.
    tx_ready = 1'b1;
    push_res(32'hDEAD_BEEF, 1'b0, 1);
    push_res(32'h0000_0010, 1'b1, 1);
    first_xfer = -1;
    drain(0, 50);
    check("b2b_span", last_xfer - first_xfer + 1, 2 * (NB + 1));
    check("b2b_end_vld", tx_valid, 0);

    // Reset mid-frame with two entries queued.
    tx_ready = 1'b1;
    push_res(32'h1111_1111, 1'b0, 1);
    push_res(32'h2222_2222, 1'b1, 1);
    push_res(32'h3333_3333, 1'b0, 1);
    check("mid_cnt", fifo_count, 2);
    prev_stall = 0;
    cycle(0);
    cycle(0);
    check("mid_two_sent", exp_dat_q.size(), 3 * (NB + 1) - 2);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_vld", tx_valid, 0);
    check("mid_rst_dat", tx_data, 0);
    check("mid_rst_last", tx_last, 0);
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    exp_dat_q.delete();
    exp_last_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    nvalid = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_valid) nvalid++;
    end
    check("post_rst_quiet", nvalid, 0);
    check("post_rst_busy", busy, 0);

    // Randomized results and backpressure, injected only within capacity.
    inflight = 0;
    sent = 0;
    n = 0;
    prev_stall = 0;
    while ((sent < 60 || exp_dat_q.size() != 0) && n < 5000) begin
      if (sent < 60 && inflight < DEPTH && $urandom_range(0, 2) != 0) begin
        res_data  = $urandom;
        res_carry = 1'($urandom_range(0, 1));
        res_valid = 1'b1;
        add_frame(res_data, res_carry);
        inflight++;
        sent++;
      end else begin
        res_valid = 1'b0;
      end
      cycle(2);
      n++;
    end
    res_valid = 1'b0;
    check("rand_done", exp_dat_q.size(), 0);
    check("rand_sent", sent, 60);
    check("rand_no_ovf", overflow, 0);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rand_end_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
